// File: rtl/program_counter_if.sv
// Control/data bundle between the jump-select stage and the program counter.
// The master drives the jump target and controls; the slave returns address and halt status.
interface program_counter_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             load;
    logic             inc;
    logic             stall;
    logic [WIDTH-1:0] out;
    logic             halted;

    modport master (
        output in, load, inc, stall,
        input  out, halted
    );

    modport slave (
        input  in, load, inc, stall,
        output out, halted
    );
endinterface

// File: rtl/program_counter.sv
// Hack CPU program counter: hold / increment / load with priority, plus a sticky
// detector for the end-of-program tight loop (repeated jumps to the same nearby target).
module program_counter #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned HALT_COUNT = 4
) (
    input  logic              clk,
    input  logic              reset,
    program_counter_if.slave  bus
);
    localparam logic [7:0] HALT_CNT = 8'(HALT_COUNT);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] last_target_q, last_target_d;
    logic [7:0]       repeat_cnt_q, repeat_cnt_d;
    logic             halted_q, halted_d;
    logic             tight;

    // A jump is tight when it targets the current address or the one just before it.
    assign tight = (bus.in == out_q) || (bus.in == out_q - WIDTH'(1));

    always_comb begin
        out_d         = out_q;
        last_target_d = last_target_q;
        repeat_cnt_d  = repeat_cnt_q;
        halted_d      = halted_q;
        if (!bus.stall) begin
            if (bus.load) begin
                out_d = bus.in;
                if (tight) begin
                    if (bus.in == last_target_q && repeat_cnt_q != 8'd0) begin
                        if (repeat_cnt_q < HALT_CNT)
                            repeat_cnt_d = repeat_cnt_q + 8'd1;
                    end else begin
                        last_target_d = bus.in;
                        repeat_cnt_d  = 8'd1;
                    end
                end else begin
                    repeat_cnt_d = 8'd0;
                end
                if (repeat_cnt_d == HALT_CNT)
                    halted_d = 1'b1;
            end else if (bus.inc) begin
                out_d = out_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q         <= '0;
            last_target_q <= '0;
            repeat_cnt_q  <= '0;
            halted_q      <= 1'b0;
        end else begin
            out_q         <= out_d;
            last_target_q <= last_target_d;
            repeat_cnt_q  <= repeat_cnt_d;
            halted_q      <= halted_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.halted = halted_q;
endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios followed by
// randomized traffic biased toward tight loops, against a behavioural model.
module tb_program_counter;
    localparam int unsigned WIDTH      = 16;
    localparam int unsigned HALT_COUNT = 4;
    localparam int unsigned MODV       = 1 << WIDTH;

    logic clk;
    logic reset;

    program_counter_if #(.WIDTH(WIDTH)) pc_if ();

    program_counter #(
        .WIDTH      (WIDTH),
        .HALT_COUNT (HALT_COUNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pc_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference state, kept as plain integers.
    int unsigned m_out, m_last, m_cnt;
    bit          m_halted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit l, input bit i, input bit s, input int unsigned v);
        bit is_tight;
        if (r) begin
            m_out = 0; m_last = 0; m_cnt = 0; m_halted = 0;
        end else if (!s) begin
            if (l) begin
                is_tight = (v == m_out) || (v == (m_out + MODV - 1) % MODV);
                if (is_tight) begin
                    if (v == m_last && m_cnt > 0)
                        m_cnt = (m_cnt + 1 > HALT_COUNT) ? HALT_COUNT : m_cnt + 1;
                    else begin
                        m_last = v;
                        m_cnt  = 1;
                    end
                end else begin
                    m_cnt = 0;
                end
                if (m_cnt == HALT_COUNT) m_halted = 1;
                m_out = v;
            end else if (i) begin
                m_out = (m_out + 1) % MODV;
            end
        end
    endtask

    task automatic step(input string tag, input bit r, input bit l, input bit i, input bit s, input int unsigned v);
        reset       = r;
        pc_if.load  = l;
        pc_if.inc   = i;
        pc_if.stall = s;
        pc_if.in    = WIDTH'(v);
        @(posedge clk);
        model_edge(r, l, i, s, v);
        #1;
        check({tag, ".out"},    32'(pc_if.out),        32'(m_out));
        check({tag, ".halted"}, 32'(pc_if.halted),     32'(m_halted));
        check({tag, ".cnt"},    32'(dut.repeat_cnt_q), 32'(m_cnt));
    endtask

    task automatic rst(input string tag);
        step(tag, 1, 0, 0, 0, 0);
    endtask

    task automatic ld(input string tag, input int unsigned v);
        step(tag, 0, 1, 0, 0, v);
    endtask

    task automatic incr(input string tag);
        step(tag, 0, 0, 1, 0, 0);
    endtask

    initial begin
        int unsigned r, v;
        m_out = 0; m_last = 0; m_cnt = 0; m_halted = 0;
        reset = 1'b1;
        pc_if.load = 1'b0; pc_if.inc = 1'b0; pc_if.stall = 1'b0; pc_if.in = '0;

        // Reset and counting
        rst("reset0");
        rst("reset1");
        check("reset_out_const", 32'(pc_if.out), 32'd0);
        for (int k = 0; k < 5; k++) incr("count");
        check("count_out_const", 32'(pc_if.out), 32'd5);

        // Priority: load beats inc, stall beats load, reset beats all
        ld("prio_pre", 10);
        step("prio_ld_inc", 0, 1, 1, 0, 'h1234);
        check("prio_ld_inc_const", 32'(pc_if.out), 32'h1234);
        step("prio_stall", 0, 1, 0, 1, 7);
        check("prio_stall_const", 32'(pc_if.out), 32'h1234);
        step("prio_reset", 1, 1, 1, 1, 9);
        check("prio_reset_const", 32'(pc_if.out), 32'd0);

        // Wrap-around; all-ones target from 0 is tight
        ld("wrap_ld", 'hFFFF);
        incr("wrap_inc");
        check("wrap_out_const", 32'(pc_if.out), 32'd0);
        ld("wrap_tight", 'hFFFF);
        check("wrap_cnt_const", 32'(dut.repeat_cnt_q), 32'd2);

        // Hack end loop: @END=20, 0;JMP at 21
        rst("halt_rst");
        ld("halt_pre", 21);
        for (int k = 0; k < 4; k++) begin
            check("halt_before", 32'(pc_if.halted), 32'd0);
            ld("halt_ld", 20);
            if (k < 3) incr("halt_inc");
        end
        check("halt_rise_const", 32'(pc_if.halted), 32'd1);

        // Non-tight break restarts the count; stall does not advance it
        rst("brk_rst");
        ld("brk_pre", 21);
        for (int k = 0; k < 3; k++) begin ld("brk_ld", 20); incr("brk_inc"); end
        ld("brk_far", 100);
        ld("brk_back", 21);
        for (int k = 0; k < 4; k++) begin
            check("brk_not_yet", 32'(pc_if.halted), 32'd0);
            ld("brk_ld2", 20);
            if (k == 1) step("brk_stall", 0, 1, 1, 1, 20);
            if (k < 3) incr("brk_inc2");
        end
        check("brk_rise_const", 32'(pc_if.halted), 32'd1);

        // Sticky until reset
        incr("sticky_inc");
        ld("sticky_far", 500);
        incr("sticky_inc2");
        check("sticky_const", 32'(pc_if.halted), 32'd1);
        rst("sticky_rst");
        check("sticky_clr_const", 32'(pc_if.halted), 32'd0);

        // Randomized traffic biased toward tight jumps
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0: v = m_out;
                1: v = (m_out + MODV - 1) % MODV;
                2: v = m_last;
                default: v = $urandom_range(0, MODV - 1);
            endcase
            step("rand", r < 2, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
